// File: rtl/bkram_pkg.sv
// Shared types and constants for the backup-RAM SD sequencer.
package bkram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck
  } bk_state_e;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_WORDS = 256;

endpackage

// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM save/load sequencer between the hps_io SD sector port and cartridge save RAM.
// Supports multiple save slots, request rejection and a completion pulse.
module bkram_sd_ctrl
  import bkram_pkg::*;
#(
  parameter int unsigned SECTORS = 128,
  parameter int unsigned SLOTS   = 1,
  parameter int unsigned SECT_W  = $clog2(SECTORS),
  parameter int unsigned SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                downloading,
  input  logic                img_mounted,
  input  logic                img_readonly,
  input  logic [63:0]         img_size,
  input  logic                load_req,
  input  logic                save_req,
  input  logic                autosave_en,
  input  logic                osd_open,
  input  logic [SLOT_W-1:0]   slot,
  input  logic                bram_change,
  output logic [31:0]         sd_lba,
  output logic                sd_rd,
  output logic                sd_wr,
  input  logic                sd_ack,
  input  logic [7:0]          sd_buff_addr,
  input  logic                sd_buff_wr,
  output logic [SECT_W+7:0]   bram_addr,
  output logic                bram_we,
  output logic                bk_ena,
  output logic                bk_loading,
  output logic                busy,
  output logic                sav_pending,
  output logic                done,
  output logic                reject
);

  bk_state_e           state_q, state_d;
  logic [SECT_W-1:0]   idx_q, idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                loading_q, loading_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                bk_ena_q, bk_ena_d;
  logic                sav_q, sav_d;
  logic                done_q, done_d;
  logic                reject_q, reject_d;

  // Registered input copies and the edge pulses derived from them.
  logic load_q, save_q, ack_q, dl_q, as_q;
  logic load_edge_q, save_edge_q, as_edge_q, ack_rise_q, ack_fall_q, dl_fall_q;

  logic        as_term;
  logic        save_edge;
  logic        auto_load;
  logic        req_ok;
  logic        start_load;
  logic        start_save;
  logic [63:0] need_bytes;

  assign as_term   = sav_q & osd_open & autosave_en;
  assign save_edge = save_edge_q | as_edge_q;
  assign auto_load = dl_fall_q & bk_ena_q & (img_size != 64'd0);

  // The selected slot must lie entirely inside the mounted image.
  assign need_bytes = (64'(slot) + 64'd1) * 64'(SECTORS) * 64'(SECTOR_BYTES);
  assign req_ok     = bk_ena_q & (32'(slot) < SLOTS) & (img_size >= need_bytes);

  assign start_load = (state_q == StIdle) & (auto_load | (load_edge_q & req_ok));
  assign start_save = (state_q == StIdle) & ~auto_load & ~load_edge_q & save_edge & req_ok;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    loading_d = loading_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    done_d    = 1'b0;
    reject_d  = 1'b0;

    case (state_q)
      StIdle: begin
        reject_d = ~auto_load & (load_edge_q | save_edge) & ~req_ok;
        if (start_load || start_save) begin
          state_d   = StReq;
          idx_d     = '0;
          slot_d    = slot;
          loading_d = start_load;
          rd_d      = start_load;
          wr_d      = start_save;
        end
      end
      StReq: begin
        if (ack_rise_q) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StAck;
        end
      end
      StAck: begin
        if (ack_fall_q) begin
          if (&idx_q) begin
            state_d   = StIdle;
            loading_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            idx_d   = idx_q + SECT_W'(1);
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bk_ena_d = bk_ena_q;
    if (downloading & ~dl_q) bk_ena_d = 1'b0;
    if (downloading & img_mounted & ~img_readonly) bk_ena_d = 1'b1;
  end

  // A write landing on the save-start cycle must survive, so set wins.
  always_comb begin
    sav_d = sav_q;
    if (start_save) sav_d = 1'b0;
    if (bram_change & ~osd_open) sav_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      slot_q      <= '0;
      loading_q   <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      bk_ena_q    <= 1'b0;
      sav_q       <= 1'b0;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
      load_q      <= 1'b0;
      save_q      <= 1'b0;
      ack_q       <= 1'b0;
      dl_q        <= 1'b0;
      as_q        <= 1'b0;
      load_edge_q <= 1'b0;
      save_edge_q <= 1'b0;
      as_edge_q   <= 1'b0;
      ack_rise_q  <= 1'b0;
      ack_fall_q  <= 1'b0;
      dl_fall_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      slot_q      <= slot_d;
      loading_q   <= loading_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      bk_ena_q    <= bk_ena_d;
      sav_q       <= sav_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
      load_q      <= load_req;
      save_q      <= save_req;
      ack_q       <= sd_ack;
      dl_q        <= downloading;
      as_q        <= as_term;
      load_edge_q <= load_req & ~load_q;
      save_edge_q <= save_req & ~save_q;
      as_edge_q   <= as_term & ~as_q;
      ack_rise_q  <= sd_ack & ~ack_q;
      ack_fall_q  <= ~sd_ack & ack_q;
      dl_fall_q   <= ~downloading & dl_q;
    end
  end

  assign sd_lba      = 32'({slot_q, idx_q});
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign bram_addr   = {idx_q, sd_buff_addr};
  assign bram_we     = sd_buff_wr & sd_ack & loading_q;
  assign bk_ena      = bk_ena_q;
  assign bk_loading  = loading_q;
  assign busy        = (state_q != StIdle);
  assign sav_pending = sav_q;
  assign done        = done_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Directed bench for bkram_sd_ctrl with a small hps_io sector responder.
module tb_bkram_sd_ctrl;

  localparam int unsigned SECTORS    = 128;
  localparam int unsigned SLOTS      = 4;
  localparam int unsigned SLOT_BYTES = SECTORS * 512;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        downloading;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic        load_req;
  logic        save_req;
  logic        autosave_en;
  logic        osd_open;
  logic [1:0]  slot;
  logic        bram_change;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = 8'd0;
  logic        sd_buff_wr = 1'b0;
  logic [14:0] bram_addr;
  logic        bram_we;
  logic        bk_ena;
  logic        bk_loading;
  logic        busy;
  logic        sav_pending;
  logic        done;
  logic        reject;

  always #5 clk_sys = ~clk_sys;

  bkram_sd_ctrl #(
    .SECTORS (SECTORS),
    .SLOTS   (SLOTS)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .load_req     (load_req),
    .save_req     (save_req),
    .autosave_en  (autosave_en),
    .osd_open     (osd_open),
    .slot         (slot),
    .bram_change  (bram_change),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_wr   (sd_buff_wr),
    .bram_addr    (bram_addr),
    .bram_we      (bram_we),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .busy         (busy),
    .sav_pending  (sav_pending),
    .done         (done),
    .reject       (reject)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // hps_io responder: records each request, acks it, writes four words, then
  // pulses sd_buff_wr once with sd_ack low to prove bram_we is gated.
  logic [31:0] lba_q[$];
  bit          rd_q[$];
  int          h_st = 0;
  int          h_cnt = 0;
  logic        h_is_rd = 1'b0;
  logic [31:0] h_lba = 32'd0;
  int          we_err = 0;
  int          we_cnt = 0;
  int          addr_err = 0;
  int          ld_err = 0;
  int          both_err = 0;
  int          done_cnt = 0;
  int          rej_cnt = 0;

  always @(negedge clk_sys) begin
    if (bram_we !== (sd_buff_wr & sd_ack & h_is_rd)) we_err++;
    if (bram_we) begin
      we_cnt++;
      if (bram_addr !== {h_lba[6:0], sd_buff_addr}) addr_err++;
    end
    if (done) done_cnt++;
    if (reject) rej_cnt++;
    if (reset) begin
      h_st = 0;
      h_cnt = 0;
      sd_ack = 1'b0;
      sd_buff_wr = 1'b0;
    end else begin
      case (h_st)
        0: begin
          sd_buff_wr = 1'b0;
          if (sd_rd || sd_wr) begin
            lba_q.push_back(sd_lba);
            rd_q.push_back(sd_rd);
            h_lba = sd_lba;
            h_is_rd = sd_rd;
            if (sd_rd && sd_wr) both_err++;
            if (bk_loading !== sd_rd) ld_err++;
            h_cnt = 0;
            h_st = 1;
          end
        end
        1: begin
          h_cnt++;
          if (h_cnt == 2) begin
            sd_ack = 1'b1;
            h_cnt = 0;
            h_st = 2;
          end
        end
        2: begin
          if (h_cnt < 8) begin
            sd_buff_addr = 8'(h_cnt / 2);
            sd_buff_wr = (h_cnt % 2 == 0);
            h_cnt++;
          end else begin
            sd_ack = 1'b0;
            sd_buff_wr = 1'b1;
            h_st = 3;
          end
        end
        default: begin
          sd_buff_wr = 1'b0;
          h_st = 0;
        end
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 50) begin
      step(1);
      n++;
    end
    check_eq(tag, busy, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      step(1);
      n++;
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic check_seq(input string tag, input int q0, input int base, input bit exp_rd);
    int errs = 0;
    for (int i = 0; i < int'(SECTORS); i++) begin
      if (lba_q[q0 + i] !== 32'(base + i) || rd_q[q0 + i] !== exp_rd) errs++;
    end
    check_eq(tag, errs, 0);
  endtask

  task automatic mount(input bit ro);
    img_readonly = ro;
    downloading = 1'b1;
    step(2);
    img_mounted = 1'b1;
    step(1);
    img_mounted = 1'b0;
    step(1);
    downloading = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q0;
    int d0;
    int r0;
    int w0;
    int n;

    reset = 1'b1;
    downloading = 1'b0;
    img_mounted = 1'b0;
    img_readonly = 1'b0;
    img_size = 64'd0;
    load_req = 1'b0;
    save_req = 1'b0;
    autosave_en = 1'b0;
    osd_open = 1'b0;
    slot = 2'd0;
    bram_change = 1'b0;
    step(3);
    check_eq("rst_sd_rd", sd_rd, 0);
    check_eq("rst_sd_wr", sd_wr, 0);
    check_eq("rst_bk_ena", bk_ena, 0);
    check_eq("rst_bk_loading", bk_loading, 0);
    check_eq("rst_sav_pending", sav_pending, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_reject", reject, 0);
    check_eq("rst_sd_lba", sd_lba, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    step(2);

    // Auto-load after a writable mount, one 64 KiB slot.
    img_size = 64'(SLOT_BYTES);
    q0 = lba_q.size();
    d0 = done_cnt;
    w0 = we_cnt;
    img_readonly = 1'b0;
    downloading = 1'b1;
    step(2);
    img_mounted = 1'b1;
    step(1);
    img_mounted = 1'b0;
    step(1);
    check_eq("arm_bk_ena", bk_ena, 1);
    downloading = 1'b0;
    wait_busy("auto_start");
    step(3);
    check_eq("auto_bk_loading", bk_loading, 1);
    wait_idle("auto_finish");
    check_eq("auto_sectors", lba_q.size() - q0, 128);
    check_seq("auto_lba_seq", q0, 0, 1'b1);
    check_eq("auto_done", done_cnt - d0, 1);
    check_eq("auto_we_cnt", we_cnt - w0, 512);
    check_eq("auto_loading_off", bk_loading, 0);

    // Slot 2 save; a write during the save leaves changes pending.
    img_size = 64'(SLOTS * SLOT_BYTES);
    bram_change = 1'b1;
    step(1);
    bram_change = 1'b0;
    step(1);
    check_eq("pend_set", sav_pending, 1);
    q0 = lba_q.size();
    d0 = done_cnt;
    w0 = we_cnt;
    slot = 2'd2;
    save_req = 1'b1;
    wait_busy("save_start");
    check_eq("save_pend_clr", sav_pending, 0);
    step(20);
    bram_change = 1'b1;
    step(1);
    bram_change = 1'b0;
    wait_idle("save_finish");
    save_req = 1'b0;
    check_eq("save_sectors", lba_q.size() - q0, 128);
    check_seq("save_lba_seq", q0, 256, 1'b0);
    check_eq("save_done", done_cnt - d0, 1);
    check_eq("save_no_we", we_cnt - w0, 0);
    check_eq("save_pend_again", sav_pending, 1);

    // Autosave disabled: opening the OSD does nothing.
    q0 = lba_q.size();
    osd_open = 1'b1;
    step(10);
    check_eq("noauto_busy", busy, 0);
    check_eq("noauto_sectors", lba_q.size() - q0, 0);
    osd_open = 1'b0;
    step(2);
    autosave_en = 1'b1;
    step(2);
    d0 = done_cnt;
    osd_open = 1'b1;
    wait_busy("autosave_start");
    wait_idle("autosave_finish");
    check_eq("autosave_sectors", lba_q.size() - q0, 128);
    check_seq("autosave_lba_seq", q0, 256, 1'b0);
    check_eq("autosave_pend_clr", sav_pending, 0);
    check_eq("autosave_done", done_cnt - d0, 1);
    osd_open = 1'b0;
    autosave_en = 1'b0;
    step(2);

    // Read-only image leaves the sequencer unarmed; load is refused.
    mount(1'b1);
    step(5);
    check_eq("ro_bk_ena", bk_ena, 0);
    check_eq("ro_no_autoload", busy, 0);
    q0 = lba_q.size();
    r0 = rej_cnt;
    load_req = 1'b1;
    step(6);
    check_eq("ro_reject", rej_cnt - r0, 1);
    check_eq("ro_sd_rd", sd_rd, 0);
    check_eq("ro_sectors", lba_q.size() - q0, 0);
    load_req = 1'b0;
    img_readonly = 1'b0;
    step(2);

    // Zero-size mount arms but does not auto-load; slot 3 of a 3-slot image is refused.
    img_size = 64'd0;
    mount(1'b0);
    step(5);
    check_eq("zero_bk_ena", bk_ena, 1);
    check_eq("zero_no_autoload", busy, 0);
    img_size = 64'(3 * SLOT_BYTES);
    slot = 2'd3;
    r0 = rej_cnt;
    save_req = 1'b1;
    step(6);
    check_eq("slot3_reject", rej_cnt - r0, 1);
    check_eq("slot3_idle", busy, 0);
    save_req = 1'b0;
    step(2);

    // Load and save edges together: load wins; a save while busy is dropped silently.
    slot = 2'd2;
    q0 = lba_q.size();
    d0 = done_cnt;
    r0 = rej_cnt;
    load_req = 1'b1;
    save_req = 1'b1;
    wait_busy("both_start");
    step(3);
    check_eq("both_first_lba", lba_q[q0], 256);
    check_eq("both_is_read", rd_q[q0], 1);
    save_req = 1'b0;
    step(2);
    save_req = 1'b1;
    step(6);
    check_eq("busy_no_reject", rej_cnt - r0, 0);
    wait_idle("both_finish");
    check_eq("both_sectors", lba_q.size() - q0, 128);
    check_seq("both_lba_seq", q0, 256, 1'b1);
    check_eq("both_done", done_cnt - d0, 1);
    step(10);
    check_eq("busy_save_dropped", busy, 0);
    load_req = 1'b0;
    save_req = 1'b0;
    step(2);

    // Reset at sector 40 of a load abandons it without a done pulse.
    slot = 2'd0;
    q0 = lba_q.size();
    d0 = done_cnt;
    load_req = 1'b1;
    n = 0;
    while (lba_q.size() < q0 + 41 && n < 2000) begin
      step(1);
      n++;
    end
    check_eq("rst_reach_sector40", lba_q.size() >= q0 + 41, 1);
    check_eq("rst_sector40_lba", lba_q[q0 + 40], 40);
    reset = 1'b1;
    load_req = 1'b0;
    step(1);
    check_eq("mid_rst_sd_rd", sd_rd, 0);
    check_eq("mid_rst_sd_wr", sd_wr, 0);
    check_eq("mid_rst_loading", bk_loading, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_bk_ena", bk_ena, 0);
    check_eq("mid_rst_sd_lba", sd_lba, 0);
    check_eq("mid_rst_no_done", done_cnt - d0, 0);
    step(2);
    reset = 1'b0;
    step(2);
    q0 = lba_q.size();
    d0 = done_cnt;
    mount(1'b0);
    wait_busy("reload_start");
    wait_idle("reload_finish");
    check_eq("reload_sectors", lba_q.size() - q0, 128);
    check_seq("reload_lba_seq", q0, 0, 1'b1);
    check_eq("reload_done", done_cnt - d0, 1);

    check_eq("bram_we_gating", we_err, 0);
    check_eq("bram_addr_map", addr_err, 0);
    check_eq("loading_vs_rd", ld_err, 0);
    check_eq("rd_wr_exclusive", both_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
